// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the four-digit seven-segment display path: arbiter
// state encoding and the display word geometry used by the arbiter and the
// display driver.
// No ports (package).
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DISP_W     = DIGIT_W * NUM_DIGITS;

    // Owner index width is fixed; NUM_REQ is limited to 2..4.
    localparam int OWNER_W    = 2;

endpackage : seven_seg_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans i_start, i_start+1, ... wrapping
// modulo N and returns the first index whose request is set and not excluded.
// Ports:
//   i_req     [N-1:0]       request vector
//   i_start   [OWNER_W-1:0] first index examined (must be < N)
//   i_exclude [N-1:0]       indices masked out of this search
//   o_found                 a winner exists
//   o_index   [OWNER_W-1:0] binary winner index (0 when none)
//   o_onehot  [N-1:0]       one-hot winner (all zero when none)
// -----------------------------------------------------------------------------
module rr_pick
    import seven_seg_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       i_req,
    input  logic [OWNER_W-1:0] i_start,
    input  logic [N-1:0]       i_exclude,
    output logic               o_found,
    output logic [OWNER_W-1:0] o_index,
    output logic [N-1:0]       o_onehot
);

    int w_pos;

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise the tool infers a latch to hold the old value.
        o_found  = 1'b0;
        o_index  = '0;
        o_onehot = '0;
        w_pos    = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(i_start) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            // Only the first hit in scan order may claim the result.
            if (!o_found && i_req[w_pos] && !i_exclude[w_pos]) begin
                o_found         = 1'b1;
                o_index         = OWNER_W'(w_pos);
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/seven_seg_arbiter.sv
// -----------------------------------------------------------------------------
// seven_seg_arbiter
// Round-robin owner selection for the shared four-digit seven-segment display.
// An owner keeps the display for at least HOLD_CYCLES cycles unless it drops
// its request; on expiry the search restarts after the owner, so a contended
// owner is displaced while a lone owner is simply retained.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   req         [NUM_REQ-1:0]        level requests
//   data        [16*NUM_REQ-1:0]     requester i value in bits [16*i+15:16*i]
//   grant       [NUM_REQ-1:0]        one-hot owner, zero when idle
//   owner_id    [1:0]                binary owner index, zero when idle
//   disp_value  [15:0]               registered copy of the owner's data
//   disp_valid                       high while an owner holds the display
// -----------------------------------------------------------------------------
module seven_seg_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [DISP_W*NUM_REQ-1:0] data,
    output logic [NUM_REQ-1:0]        grant,
    output logic [OWNER_W-1:0]        owner_id,
    output logic [DISP_W-1:0]         disp_value,
    output logic                      disp_valid
);

    localparam int                 CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_REQ - 1);

    state_t               r_state,      w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant,      w_grant_nxt;
    logic [OWNER_W-1:0]   r_owner_id,   w_owner_nxt;
    logic [OWNER_W-1:0]   r_last_owner, w_last_nxt;
    logic [DISP_W-1:0]    r_disp_value, w_value_nxt;
    logic                 r_disp_valid, w_valid_nxt;
    logic [CNT_W-1:0]     r_hold_cnt,   w_cnt_nxt;

    logic [DISP_W-1:0]    w_slot [NUM_REQ];
    logic                 w_release;
    logic                 w_expire;
    logic [OWNER_W-1:0]   w_start;
    logic [NUM_REQ-1:0]   w_exclude;
    logic                 w_found;
    logic [OWNER_W-1:0]   w_index;
    logic [NUM_REQ-1:0]   w_onehot;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign w_slot[i] = data[DISP_W*i +: DISP_W];
    end

    assign w_release = (r_state == ST_HOLD) && !req[r_owner_id];
    assign w_expire  = (r_state == ST_HOLD) && (r_hold_cnt == CNT_LAST);

    // Search always begins just after the last owner (wrapping), which in HOLD
    // is the current owner itself.
    assign w_start   = (r_last_owner == LAST_IDX) ? '0 : r_last_owner + OWNER_W'(1);

    // A releasing owner is kept out of its own re-arbitration; on a plain
    // expiry it stays eligible so a lone requester is retained.
    assign w_exclude = w_release ? r_grant : '0;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .i_req     (req),
        .i_start   (w_start),
        .i_exclude (w_exclude),
        .o_found   (w_found),
        .o_index   (w_index),
        .o_onehot  (w_onehot)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner_id;
        w_last_nxt  = r_last_owner;
        w_value_nxt = w_slot[r_owner_id];
        w_valid_nxt = r_disp_valid;
        w_cnt_nxt   = r_hold_cnt + CNT_W'(1);

        // Arbitrate when idle, on release, or on window expiry. Release takes
        // precedence simply because it sets the exclude mask.
        if ((r_state == ST_IDLE) || w_release || w_expire) begin
            if (w_found) begin
                w_state_nxt = ST_HOLD;
                w_grant_nxt = w_onehot;
                w_owner_nxt = w_index;
                w_last_nxt  = w_index;
                w_value_nxt = w_slot[w_index];
                w_valid_nxt = 1'b1;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_value_nxt = '0;
                w_valid_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        end
    end

    // Reset leaves the pointer on the highest index so requester 0 is
    // examined first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner_id   <= '0;
            r_last_owner <= LAST_IDX;
            r_disp_value <= '0;
            r_disp_valid <= 1'b0;
            r_hold_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner_id   <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_disp_value <= w_value_nxt;
            r_disp_valid <= w_valid_nxt;
            r_hold_cnt   <= w_cnt_nxt;
        end
    end

    assign grant      = r_grant;
    assign owner_id   = r_owner_id;
    assign disp_value = r_disp_value;
    assign disp_valid = r_disp_valid;

endmodule : seven_seg_arbiter

// File: tb/tb_seven_seg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_arbiter
// Self-checking bench for seven_seg_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
// Inputs change on the falling edge; outputs are compared on the following
// falling edge against expectations queued when the stimulus was applied.
// -----------------------------------------------------------------------------
module tb_seven_seg_arbiter;

    localparam int NREQ = 4;
    localparam int HOLD = 4;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] data;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] value;
    } vec_t;

    typedef struct {
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] value;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic [63:0]     data;
    logic [NREQ-1:0] grant;
    logic [1:0]      owner_id;
    logic [15:0]     disp_value;
    logic            disp_valid;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    seven_seg_arbiter #(
        .NUM_REQ     (NREQ),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .grant      (grant),
        .owner_id   (owner_id),
        .disp_value (disp_value),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    // Grant must never have more than one bit set, in any cycle.
    always @(negedge clk) begin
        assert ($onehot0(grant)) else begin
            n_errors++;
            $display("FAIL grant_onehot: grant=%b, required at most one bit set", grant);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] r,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [15:0] d2, input logic [15:0] d3,
                                 input logic [3:0] g, input logic [1:0] o,
                                 input logic v, input logic [15:0] val);
        vec_t t;
        t.req   = r;
        t.data  = {d3, d2, d1, d0};
        t.grant = g;
        t.owner = o;
        t.valid = v;
        t.value = val;
        return t;
    endfunction

    // Called on a falling edge: drive, queue the expectation, compare after
    // the next rising edge on the following falling edge.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        req  = v.req;
        data = v.data;
        e.grant = v.grant;
        e.owner = v.owner;
        e.valid = v.valid;
        e.value = v.value;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, " grant"},    {28'b0, grant},      {28'b0, e.grant});
        check({tag, " owner_id"}, {30'b0, owner_id},   {30'b0, e.owner});
        check({tag, " valid"},    {31'b0, disp_valid}, {31'b0, e.valid});
        check({tag, " value"},    {16'b0, disp_value}, {16'b0, e.value});
    endtask

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("%s[%0d]", tag, i));
        end
        tbl.delete();
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (2) @(negedge clk);
        check("reset grant",    {28'b0, grant},      32'h0);
        check("reset owner_id", {30'b0, owner_id},   32'h0);
        check("reset valid",    {31'b0, disp_valid}, 32'h0);
        check("reset value",    {16'b0, disp_value}, 32'h0);
        rst = 1'b0;

        // Idle with no requests for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0, 16'h0000));
        end
        run_tbl("idle");

        // Contention between 0 and 2: switch every HOLD edges.
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mkv(4'b0101, 16'h1234, 16'h1111, 16'hABCD, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h1234));
        end
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mkv(4'b0101, 16'h1234, 16'h1111, 16'hABCD, 16'h3333, 4'b0100, 2'd2, 1'b1, 16'hABCD));
        end
        tbl.push_back(mkv(4'b0101, 16'h1234, 16'h1111, 16'hABCD, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h1234));
        tbl.push_back(mkv(4'b0000, 16'h1234, 16'h1111, 16'hABCD, 16'h3333, 4'b0000, 2'd0, 1'b0, 16'h0000));
        run_tbl("rr02");

        // Lone requester 1 across several expiries, data tracked with 1-cycle lag.
        for (int i = 0; i < 12; i++) begin
            tbl.push_back(mkv(4'b0010, 16'h0, 16'(16'hC000 + i), 16'h0, 16'h0,
                              4'b0010, 2'd1, 1'b1, 16'(16'hC000 + i)));
        end
        tbl.push_back(mkv(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 2'd0, 1'b0, 16'h0000));
        run_tbl("lone1");

        // Owner 0 releases early; 3 takes over with a fresh window while 0
        // waits, then 3 is retained alone and finally releases to idle.
        tbl.push_back(mkv(4'b0001, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h0A0A));
        tbl.push_back(mkv(4'b1001, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h0A0A));
        tbl.push_back(mkv(4'b1000, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b1000, 2'd3, 1'b1, 16'h3333));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mkv(4'b1001, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b1000, 2'd3, 1'b1, 16'h3333));
        end
        tbl.push_back(mkv(4'b1000, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b1000, 2'd3, 1'b1, 16'h3333));
        tbl.push_back(mkv(4'b1000, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b1000, 2'd3, 1'b1, 16'h3333));
        tbl.push_back(mkv(4'b0000, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 2'd0, 1'b0, 16'h0000));
        run_tbl("early_rel");

        // Owner 0 drops its request exactly on the expiry edge while 1 waits.
        tbl.push_back(mkv(4'b0001, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h0A0A));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mkv(4'b0011, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h0A0A));
        end
        tbl.push_back(mkv(4'b0010, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0010, 2'd1, 1'b1, 16'h1111));
        tbl.push_back(mkv(4'b0010, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0010, 2'd1, 1'b1, 16'h1111));
        tbl.push_back(mkv(4'b0000, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0000, 2'd0, 1'b0, 16'h0000));
        run_tbl("rel_on_exp");

        // Owner 2 in HOLD, then asynchronous reset between clock edges.
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mkv(4'b0100, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0100, 2'd2, 1'b1, 16'h2222));
        end
        run_tbl("own2");
        #2;
        rst = 1'b1;
        req = 4'b1111;
        #1;
        check("async_rst grant",    {28'b0, grant},      32'h0);
        check("async_rst owner_id", {30'b0, owner_id},   32'h0);
        check("async_rst valid",    {31'b0, disp_valid}, 32'h0);
        check("async_rst value",    {16'b0, disp_value}, 32'h0);
        @(negedge clk);
        check("rst_held grant",     {28'b0, grant},      32'h0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tbl.push_back(mkv(4'b1111, 16'h0A0A, 16'h1111, 16'h2222, 16'h3333, 4'b0001, 2'd0, 1'b1, 16'h0A0A));
        end
        run_tbl("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seven_seg_arbiter

// File: doc/seven_seg_arbiter.md
# seven_seg_arbiter

Round-robin arbiter that shares the single four-digit seven-segment display between up to NUM_REQ requesters (e.g. counter, switch readback, debug value). Each requester presents a 16-bit value and a request. The arbiter grants one owner at a time, holds it for a minimum display window, and drives the 16-bit value input of the four-digit display driver plus a valid flag used to blank the anodes when nobody owns the display.

## Interface
- NUM_REQ, 4: number of requesters (2..4); owner_id width fixed at 2 bits.
- HOLD_CYCLES, 50_000_000: minimum ownership window in clk cycles (≥2); counter width $clog2(HOLD_CYCLES).
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester display request, level-sensitive.
- data  input  16*NUM_REQ  requester i value in bits [16*i+15:16*i].
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- owner_id  output  2  binary index of current owner; 0 when idle.
- disp_value  output  16  value for the display driver; registered copy of owner's data.
- disp_valid  output  1  high while an owner holds the display; top level blanks anodes (4'b1111) when low.

## Operation
- States: IDLE (no owner), HOLD (owner valid, hold counter running).
- Round-robin pointer last_owner. Search order for a new owner is last_owner+1, +2, … wrapping mod NUM_REQ. The first index with req=1 wins.
- IDLE: if any req=1 at an edge, pick the winner, load grant/owner_id, set last_owner=winner, capture disp_value=data[winner], set disp_valid=1, clear hold_cnt, and go to HOLD. Otherwise all outputs stay 0.
- HOLD, every edge: disp_value <= data[owner] (live tracking); hold_cnt increments.
- HOLD, owner's req=0 at an edge (early release): re-arbitrate immediately among the remaining requesters. A winner gets a fresh HOLD with hold_cnt=0. If there is no winner, go to IDLE: grant=0, owner_id=0, disp_valid=0, disp_value=0.
- HOLD, hold_cnt==HOLD_CYCLES-1 at an edge (expiry): re-arbitrate starting after the current owner.
  - Another requester wins: switch owner.
  - Only the owner is requesting: the owner is retained and hold_cnt restarts at 0.
  - This guarantees an owner is displaced after at most HOLD_CYCLES cycles when contended.
- Early release and expiry in the same edge: treated as early release (the owner is excluded).
- Requests from non-owners during HOLD have no effect until expiry or release.
- req bits ≥ NUM_REQ do not exist; data for unused slots is ignored.

## Timing
- Reset (async, immediate): state=IDLE, grant=0, owner_id=0, disp_value=0, disp_valid=0, hold_cnt=0, last_owner=NUM_REQ-1, so requester 0 has first priority after reset.
- Grant latency: req rising before edge k gives grant/disp_valid/disp_value valid after edge k (1 cycle).
- Release latency: req falling before edge k gives grant dropped or reassigned after edge k.
- disp_value follows data[owner] with exactly 1-cycle latency while in HOLD.
- Owner switch on contention occurs on the HOLD_CYCLES-th edge after the grant edge. grant changes in a single edge, with no idle gap and never two bits set.
- Reset asserted mid-HOLD: outputs go to reset values without waiting for clk. The first arbitration after deassertion starts at requester 0.

## Structure
- Shared package seven_seg_pkg holds:
  - state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1;
  - the DIGIT_W=4 and DISP_W=16 constants, shared with the display driver.
- Sub-module rr_pick (combinational, parameter N) takes req, the start index and an exclude mask, and returns found, index and one-hot. It is used for both the IDLE grant and HOLD re-arbitration.
- All registers live in seven_seg_arbiter, in one always block with async reset.

## Test plan
All scenarios use HOLD_CYCLES=4 and NUM_REQ=4.
- Reset release with req=4'b0000 → grant=0, disp_valid=0, disp_value=16'h0000 held for 10 cycles.
- req=4'b0101, data0=16'h1234, data2=16'hABCD → grant=0001 and disp_value=1234 one cycle later; after 4 edges grant=0100 and disp_value=ABCD; after 4 more edges back to 0001.
- Only req[1] high for 12 cycles with data1 changing each cycle → grant stays 0010 continuously, disp_value equals the previous cycle's data1.
- Owner 0 drops req after 2 cycles while req[3]=1 → grant=1000 on the next edge with a fresh 4-cycle window. Then drop req[3] → IDLE, disp_valid=0, disp_value=0.
- Assert rst asynchronously mid-HOLD with owner 2 → all outputs 0 before the next clk edge. After release with req=4'b1111, the first grant is 0001.
- Owner releases exactly on its expiry edge while req[1]=1 → grant moves to 0010 in one edge, never two grant bits set (checked every cycle by an assertion).
